// File: rtl/data_mem_responder_pkg.sv
// Shared constants for the memory-stage data interface: FSM state encodings
// and default bus widths, also used by the memory-stage module.
package data_mem_responder_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 8;
  localparam int unsigned DEF_DATA_WIDTH = 32;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WAIT    = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;
  localparam logic [1:0] RELEASE = 2'd3;

endpackage

// File: rtl/data_mem_responder_if.sv
// Memory-stage data bus: the requester drives the master side and the
// data memory responds on the slave side.
interface data_mem_responder_if
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
);
  logic                  memRead;
  logic                  memWrite;
  logic [ADDR_WIDTH-1:0] memAddress;
  logic [DATA_WIDTH-1:0] writeData;
  logic [DATA_WIDTH-1:0] readData;
  logic                  memReady;
  logic                  memError;

  modport master (
    output memRead,
    output memWrite,
    output memAddress,
    output writeData,
    input  readData,
    input  memReady,
    input  memError
  );

  modport slave (
    input  memRead,
    input  memWrite,
    input  memAddress,
    input  writeData,
    output readData,
    output memReady,
    output memError
  );

endinterface

// File: rtl/data_mem_responder_mem_word_array.sv
// Word storage with synchronous write, registered read port and an
// asynchronous clear of every word and of the read register.
module data_mem_responder_mem_word_array #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned IDX_WIDTH   = 6
) (
  input  logic                  clock,
  input  logic                  start,
  input  logic                  we,
  input  logic                  re,
  input  logic [IDX_WIDTH-1:0]  idx,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clock or posedge start) begin
    if (start) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem_q[i] <= '0;
      end
      rdata_q <= '0;
    end else begin
      if (we) begin
        mem_q[idx] <= wdata;
      end
      // Holds its value unless a successful read completes.
      if (re) begin
        rdata_q <= mem_q[idx];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Handshaked multi-cycle data memory: accepts one request, waits LATENCY
// cycles, pulses memReady (optionally with memError), then waits for release.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned LATENCY     = 2
) (
  input logic                 clock,
  input logic                 start,
  data_mem_responder_if.slave bus
);

  localparam int unsigned IDX_WIDTH = ADDR_WIDTH - 2;

  logic [1:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  write_q, write_d;
  logic [IDX_WIDTH-1:0]  idx_q, idx_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  ready_q, ready_d;
  logic                  error_q, error_d;

  logic                  req;
  logic                  bad;
  logic [IDX_WIDTH-1:0]  in_idx;
  logic                  acc_we;
  logic                  acc_re;
  logic [IDX_WIDTH-1:0]  acc_idx;
  logic [DATA_WIDTH-1:0] acc_wdata;
  logic [DATA_WIDTH-1:0] rdata;

  assign req    = bus.memRead | bus.memWrite;
  assign in_idx = bus.memAddress[ADDR_WIDTH-1:2];
  assign bad    = (bus.memRead & bus.memWrite) | (bus.memAddress[1:0] != 2'b00) |
                  (32'(in_idx) >= DEPTH_WORDS);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    write_d   = write_q;
    idx_d     = idx_q;
    data_d    = data_q;
    ready_d   = 1'b0;
    error_d   = 1'b0;
    acc_we    = 1'b0;
    acc_re    = 1'b0;
    acc_idx   = idx_q;
    acc_wdata = data_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          write_d = bus.memWrite;
          idx_d   = in_idx;
          data_d  = bus.writeData;
          if (bad) begin
            state_d = DONE;
            ready_d = 1'b1;
            error_d = 1'b1;
          end else if (LATENCY == 0) begin
            // Zero latency: access straight from the bus on the accepting edge.
            state_d   = DONE;
            ready_d   = 1'b1;
            acc_we    = bus.memWrite;
            acc_re    = bus.memRead;
            acc_idx   = in_idx;
            acc_wdata = bus.writeData;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = DONE;
          ready_d = 1'b1;
          acc_we  = write_q;
          acc_re  = ~write_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: state_d = RELEASE;
      RELEASE: begin
        if (!req) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge start) begin
    if (start) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      write_q <= 1'b0;
      idx_q   <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      error_q <= error_d;
    end
  end

  data_mem_responder_mem_word_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_WIDTH  (IDX_WIDTH)
  ) u_array (
    .clock(clock),
    .start(start),
    .we   (acc_we),
    .re   (acc_re),
    .idx  (acc_idx),
    .wdata(acc_wdata),
    .rdata(rdata)
  );

  assign bus.readData = rdata;
  assign bus.memReady = ready_q;
  assign bus.memError = error_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: three responders (LATENCY 0, 2, 15) see identical traffic
// and each response is checked against hand-computed latency, data and error.
module tb_data_mem_responder;
  import data_mem_responder_pkg::*;

  logic clock = 1'b0;
  logic start;
  always #5 clock = ~clock;

  logic        mem_read;
  logic        mem_write;
  logic [7:0]  mem_addr;
  logic [31:0] wdata;

  data_mem_responder_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus0 ();
  data_mem_responder_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus2 ();
  data_mem_responder_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus15 ();

  assign bus0.memRead     = mem_read;
  assign bus0.memWrite    = mem_write;
  assign bus0.memAddress  = mem_addr;
  assign bus0.writeData   = wdata;
  assign bus2.memRead     = mem_read;
  assign bus2.memWrite    = mem_write;
  assign bus2.memAddress  = mem_addr;
  assign bus2.writeData   = wdata;
  assign bus15.memRead    = mem_read;
  assign bus15.memWrite   = mem_write;
  assign bus15.memAddress = mem_addr;
  assign bus15.writeData  = wdata;

  data_mem_responder #(.LATENCY(0)) u_dut0 (
    .clock(clock),
    .start(start),
    .bus  (bus0)
  );
  data_mem_responder #(.LATENCY(2)) u_dut2 (
    .clock(clock),
    .start(start),
    .bus  (bus2)
  );
  data_mem_responder #(.LATENCY(15)) u_dut15 (
    .clock(clock),
    .start(start),
    .bus  (bus15)
  );

  logic        rdy [3];
  logic        erv [3];
  logic [31:0] rdv [3];
  assign rdy[0] = bus0.memReady;
  assign rdy[1] = bus2.memReady;
  assign rdy[2] = bus15.memReady;
  assign erv[0] = bus0.memError;
  assign erv[1] = bus2.memError;
  assign erv[2] = bus15.memError;
  assign rdv[0] = bus0.readData;
  assign rdv[1] = bus2.readData;
  assign rdv[2] = bus15.readData;

  int unsigned lats [3] = '{0, 2, 15};
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Holds the request 20 cycles so a held request must not be serviced twice.
  task automatic xact(input string name, input logic rd, input logic wr, input logic [7:0] addr,
                      input logic [31:0] data, input logic exp_err, input logic [31:0] exp_rd);
    int          lat [3];
    int          np [3];
    logic [31:0] got_rd [3];
    logic        got_err [3];
    for (int k = 0; k < 3; k++) begin
      lat[k]     = -1;
      np[k]      = 0;
      got_rd[k]  = 'x;
      got_err[k] = 1'bx;
    end
    @(negedge clock);
    mem_read  = rd;
    mem_write = wr;
    mem_addr  = addr;
    wdata     = data;
    for (int c = 0; c < 20; c++) begin
      @(posedge clock);
      #1;
      for (int k = 0; k < 3; k++) begin
        if (rdy[k]) begin
          if (np[k] == 0) begin
            lat[k]     = c;
            got_rd[k]  = rdv[k];
            got_err[k] = erv[k];
          end
          np[k]++;
        end
      end
    end
    check({name, " held state"}, 32'(u_dut2.state_q), 32'(RELEASE));
    @(negedge clock);
    mem_read  = 1'b0;
    mem_write = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clock);
      #1;
      for (int k = 0; k < 3; k++) begin
        if (rdy[k]) np[k]++;
      end
    end
    check({name, " idle state"}, 32'(u_dut2.state_q), 32'(IDLE));
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s L%0d latency", name, lats[k]), 32'(lat[k]),
            exp_err ? 32'd0 : 32'(lats[k]));
      check($sformatf("%s L%0d pulses", name, lats[k]), 32'(np[k]), 32'd1);
      check($sformatf("%s L%0d error", name, lats[k]), 32'(got_err[k]), 32'(exp_err));
      check($sformatf("%s L%0d readData", name, lats[k]), got_rd[k], exp_rd);
    end
  endtask

  initial begin
    start     = 1'b1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    wdata     = '0;
    repeat (2) @(negedge clock);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset L%0d ready", lats[k]), 32'(rdy[k]), 32'd0);
      check($sformatf("reset L%0d error", lats[k]), 32'(erv[k]), 32'd0);
      check($sformatf("reset L%0d readData", lats[k]), rdv[k], 32'd0);
    end
    start = 1'b0;

    xact("rd 3c unwritten", 1'b1, 1'b0, 8'h3c, 32'h0, 1'b0, 32'h0000_0000);
    xact("wr 10", 1'b0, 1'b1, 8'h10, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000);
    xact("rd 10", 1'b1, 1'b0, 8'h10, 32'h0, 1'b0, 32'hDEAD_BEEF);
    xact("rd 11 misaligned", 1'b1, 1'b0, 8'h11, 32'h0, 1'b1, 32'hDEAD_BEEF);
    xact("rd+wr 10", 1'b1, 1'b1, 8'h10, 32'h0000_0055, 1'b1, 32'hDEAD_BEEF);
    xact("wr 04", 1'b0, 1'b1, 8'h04, 32'hCAFE_F00D, 1'b0, 32'hDEAD_BEEF);
    xact("rd 04", 1'b1, 1'b0, 8'h04, 32'h0, 1'b0, 32'hCAFE_F00D);
    xact("rd 10 after err", 1'b1, 1'b0, 8'h10, 32'h0, 1'b0, 32'hDEAD_BEEF);

    // Abort a write to 0x08 while the LATENCY=2 responder is still waiting.
    @(negedge clock);
    mem_write = 1'b1;
    mem_addr  = 8'h08;
    wdata     = 32'h1234_5678;
    @(posedge clock);
    @(posedge clock);
    #1;
    check("midop pre-reset state", 32'(u_dut2.state_q), 32'(WAIT));
    start = 1'b1;
    #1;
    check("midop readData", rdv[1], 32'd0);
    check("midop ready", 32'(rdy[1]), 32'd0);
    check("midop error", 32'(erv[1]), 32'd0);
    check("midop state", 32'(u_dut2.state_q), 32'(IDLE));
    check("midop L15 readData", rdv[2], 32'd0);
    mem_write = 1'b0;
    @(negedge clock);
    start = 1'b0;

    xact("rd 08 after reset", 1'b1, 1'b0, 8'h08, 32'h0, 1'b0, 32'h0000_0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Responder end of the memory-stage data interface. The processor's memory stage issues memRead/memWrite with an address and write data. This block serves each request from an internal word array after a configurable number of wait cycles, then returns memReady plus read data or an error flag. It sits beside the memory stage in mipsProcessor and replaces a zero-latency array with a handshaked, multi-cycle data memory.

Parameters:
ADDR_WIDTH, 8, byte-address width of memAddress
DATA_WIDTH, 32, word width
DEPTH_WORDS, 64, number of implemented words; legal word index range is 0..DEPTH_WORDS-1
LATENCY, 2, wait cycles between acceptance and response; legal range 0..15

Ports:
clock  input  1  system clock, rising edge
start  input  1  reset, asynchronous, active-high
memRead  input  1  read request, level, held until memReady seen
memWrite  input  1  write request, level, held until memReady seen
memAddress  input  ADDR_WIDTH  byte address; word index = memAddress[ADDR_WIDTH-1:2]
writeData  input  DATA_WIDTH  store data, stable while memWrite high
readData  output  DATA_WIDTH  load result, valid while memReady high
memReady  output  1  one-cycle completion pulse
memError  output  1  qualifies memReady: request rejected

Behaviour:
- Clocking and reset: single clock `clock`; `start` is asynchronous, active-high.
- While start=1:
  - FSM=IDLE, counter=0.
  - readData=0, memReady=0, memError=0.
  - All array words cleared to 0.
  - Any in-flight request is abandoned and no write is committed.
- FSM states: IDLE, WAIT, DONE, RELEASE. Outputs are registered.
- IDLE:
  - A request is memRead|memWrite sampled at rising edge N.
  - Address, data and direction are latched at edge N. Later input changes are ignored until RELEASE.
- Error conditions, checked at edge N:
  - memRead and memWrite both high.
  - memAddress[1:0] != 0.
  - Word index >= DEPTH_WORDS.
  - On error: go directly to DONE at edge N with memError=1. No array access; readData unchanged.
- Normal request:
  - LATENCY=0: go to DONE at edge N.
  - Otherwise: go to WAIT with counter=LATENCY-1.
- WAIT: each edge decrements the counter. At the edge where counter==0, go to DONE. DONE is therefore entered at edge N+LATENCY.
- Entering DONE (same edge):
  - Write: array[index] <= latched data.
  - Read: readData <= array[index].
  - memReady=1 for exactly the one DONE cycle; memError=0 for normal requests.
- DONE always goes to RELEASE at the next edge; memReady and memError return to 0.
- RELEASE: stay until memRead=0 and memWrite=0 at an edge, then go to IDLE. This prevents a held request from being serviced twice. The minimum gap between accepted requests is one IDLE cycle.
- readData holds its last value across writes, errors and idle periods. It changes only on a successful read or on reset.
- A read from a never-written word returns 0.
- Read-after-write to the same address across separate transactions returns the new data.
- The counter is 4 bits wide.

Decomposition:
- Shared package holds:
  - FSM state encoding constants: IDLE=2'd0, WAIT=2'd1, DONE=2'd2, RELEASE=2'd3.
  - DATA_WIDTH and ADDR_WIDTH defaults, shared with the memory-stage module.
- One natural sub-module: mem_word_array. It provides the storage, synchronous write, synchronous read and async clear. The FSM, checks and counter stay in data_mem_responder.

Test Plan:
- Write then read, LATENCY=2:
  - memWrite, addr 0x10, data 0xDEADBEEF, accepted at edge N -> memReady high in the cycle after edge N+2, memError=0.
  - Drop request, then memRead addr 0x10 -> readData=0xDEADBEEF with memReady after the same latency.
- Unwritten read: memRead addr 0x3C after reset -> readData=0x00000000, memReady once.
- Errors:
  - memRead addr 0x11 -> memReady and memError=1 in the cycle after edge N; readData unchanged.
  - memRead and memWrite both high -> same response, and the array is unmodified (verify by read-back).
- Held request: memRead held high for 10 cycles -> exactly one memReady pulse; FSM stays in RELEASE until memRead drops.
- Reset mid-operation: memWrite addr 0x08 data 0x12345678, start asserted during WAIT -> outputs 0 immediately (asynchronously). A later read of 0x08 returns 0.
- Latency sweep: LATENCY=0 and LATENCY=15 on read addr 0x04 -> memReady after edge N and after edge N+15 respectively.
